piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in, serial-out transmitter: the sending end of the team's 1-bit serial link, whose receiver inserts each bit at the MSB of a shift register and shifts right. The block accepts a WIDTH-bit word through a valid/ready load handshake and drives it LSB-first on a single serial line, one bit per clock, with frame qualifiers. It sits between a parallel producer and the serial wire.

## Interface
- WIDTH, 4: data word width in bits; legal range is WIDTH ≥ 2.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- load_valid_i  in  1  producer presents a word on load_data_i.
- load_data_i  in  WIDTH  word to serialize; sampled only on accept.
- load_ready_o  out  1  block can accept a word this cycle.
- x_o  out  1  serial data, LSB first.
- x_valid_o  out  1  x_o carries a frame bit this cycle.
- last_o  out  1  x_o carries the final bit of the frame.
- busy_o  out  1  a frame is in progress.

## Operation
- Two states: IDLE and SHIFT. The reset state is IDLE.
- Accept means load_valid_i && load_ready_o at a rising edge. On accept, load_data_i is captured into shift register sr, the bit counter is cleared, and the state becomes SHIFT.
- load_ready_o = (state == IDLE) || (state == SHIFT && last_o). It depends on registered state only and has no combinational path from any input.
- In SHIFT:
  - x_o = sr[0] and x_valid_o = 1.
  - At each edge, sr shifts right (a 0 enters the MSB) and the counter increments.
- last_o is high while in SHIFT with counter == FRAME_LEN-1.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the parity option enabled (see Configuration).
  - Counter width is $clog2(FRAME_LEN).
- At the edge that ends the last bit:
  - With an accept on that edge: reload sr, clear the counter, and stay in SHIFT. Back-to-back frames have no idle gap.
  - Without an accept: go to IDLE.
- In IDLE: x_o = 0, x_valid_o = 0, last_o = 0, busy_o = 0.
- busy_o = (state == SHIFT).
- While in SHIFT and not on the last bit, load_valid_i is ignored. The producer must hold the word until load_ready_o is high.
- Reset asserted mid-frame aborts the frame. There is no resume and no partial bits after reset.

## Timing
- Reset values: state = IDLE, sr = 0, counter = 0, x_o = 0, x_valid_o = 0, last_o = 0, busy_o = 0, load_ready_o = 1.
- Accept at edge N → bit k (k = 0 is the LSB) is on x_o from edge N+k to edge N+k+1.
- last_o is high from edge N+FRAME_LEN-1 to edge N+FRAME_LEN.
- Throughput: one word per FRAME_LEN cycles, sustained.
- A right-shifting, MSB-insert receiver sampling x_o on the same edges holds the word after edge N+WIDTH.

## Configuration
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1.
  - After the data MSB, one even-parity bit is sent, equal to the XOR of the captured word.
  - Parity is computed at capture and held in a register.
  - last_o marks the parity bit.
- Undefined: FRAME_LEN = WIDTH, no parity logic is present, and last_o marks the data MSB.

## Structure
- Package piso_tx_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_e.
  - function even_parity(), used by both the RTL and the bench.
- No sub-module: the FSM, counter and shift register stay in one module.

## Test plan
- Reset: assert reset while the clock is running → all outputs take their reset values immediately. After release, load_ready_o = 1 and x_valid_o = 0.
- Single frame, WIDTH = 4: load 4'b1011 → x_o = 1, 1, 0, 1 on 4 consecutive cycles, x_valid_o high for 4 cycles, last_o on the 4th bit only. A looped-back MSB-insert receiver reads 4'hB.
- Back-to-back: hold load_valid_i with 4'hA, then 4'h5 on the cycle load_ready_o reasserts → x_o = 0, 1, 0, 1, 1, 0, 1, 0 with x_valid_o high for 8 consecutive cycles, then IDLE.
- Stall: assert load_valid_i with 4'h3 during bit 1 of a frame → not accepted. It is accepted on the last-bit edge, and its bits follow with no gap.
- Reset mid-frame: assert reset after 2 bits of 4'hF → x_o = 0 and busy_o = 0 immediately. The next load of 4'h6 sends 0, 1, 1, 0 from a fresh counter.
- With PISO_TX_PARITY_EN defined: load 4'b0111 → x_o = 1, 1, 1, 0, 1 (parity 1), last_o on the 5th bit. Loading 4'b0011 gives a parity bit of 0.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
// even_parity() is used by both the RTL and the bench.
package piso_tx_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_e;

  // Widest word even_parity() accepts; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: WIDTH-bit word sent LSB-first with frame qualifiers.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit after the data MSB.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             last_o,
  output logic             busy_o
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  piso_state_e      r_state;
  piso_state_e      w_next_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_accept;

  // Handshake: a word is taken on any edge where valid and ready are both high.
  // Ready depends only on registered state, so there is no input-to-ready path.
  assign w_last       = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign load_ready_o = (r_state == IDLE) || w_last;
  assign w_accept     = load_valid_i && load_ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SHIFT;
      SHIFT:   if (w_last && !w_accept) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

`ifdef PISO_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_parity <= 1'b0;
    else if (w_accept) r_parity <= even_parity(PARITY_MAX_W'(load_data_i));
  end
`endif

  always_comb begin
    x_o       = 1'b0;
    x_valid_o = 1'b0;
    last_o    = 1'b0;
    busy_o    = 1'b0;
    if (r_state == SHIFT) begin
      x_valid_o = 1'b1;
      busy_o    = 1'b1;
      last_o    = w_last;
`ifdef PISO_TX_PARITY_EN
      x_o       = w_last ? r_parity : r_sr[0];
`else
      x_o       = r_sr[0];
`endif
    end
  end

  // Counter returns to zero after the final bit so IDLE always holds a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sr  <= load_data_i;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sr  <= {1'b0, r_sr[WIDTH-1:1]};
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx (WIDTH = 4); define PISO_TX_PARITY_EN for the parity build.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_piso_tx;
  import piso_tx_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid_i;
  logic [WIDTH-1:0] load_data_i;
  logic             load_ready_o;
  logic             x_o;
  logic             x_valid_o;
  logic             last_o;
  logic             busy_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] rx;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .x_o          (x_o),
    .x_valid_o    (x_valid_o),
    .last_o       (last_o),
    .busy_o       (busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One in-frame bit: serial value, qualifiers, and ready (high only on the last bit).
  task automatic chk_bit(input string tag, input logic exp_x, input logic exp_last);
    chk({tag, " x_o"}, x_o, exp_x);
    chk({tag, " x_valid_o"}, x_valid_o, 1'b1);
    chk({tag, " last_o"}, last_o, exp_last);
    chk({tag, " busy_o"}, busy_o, 1'b1);
    chk({tag, " load_ready_o"}, load_ready_o, exp_last);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " x_o"}, x_o, 1'b0);
    chk({tag, " x_valid_o"}, x_valid_o, 1'b0);
    chk({tag, " last_o"}, last_o, 1'b0);
    chk({tag, " busy_o"}, busy_o, 1'b0);
    chk({tag, " load_ready_o"}, load_ready_o, 1'b1);
  endtask

  task automatic load(input logic [WIDTH-1:0] d);
    load_valid_i = 1'b1;
    load_data_i  = d;
    tick();
    load_valid_i = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    tick();
    tick();
    chk_idle("reset_hold");
    reset = 1'b0;
    tick();
    chk_idle("after_reset");

    chk("parity_fn_b", even_parity(PARITY_MAX_W'(4'hB)), 1'b1);
    chk("parity_fn_3", even_parity(PARITY_MAX_W'(4'h3)), 1'b0);

`ifndef PISO_TX_PARITY_EN
    // Single frame 4'b1011 -> 1,1,0,1; MSB-insert receiver rebuilds 4'hB.
    rx = '0;
    load(4'hB);
    chk_bit("single b0", 1'b1, 1'b0); rx = {x_o, rx[WIDTH-1:1]}; tick();
    chk_bit("single b1", 1'b1, 1'b0); rx = {x_o, rx[WIDTH-1:1]}; tick();
    chk_bit("single b2", 1'b0, 1'b0); rx = {x_o, rx[WIDTH-1:1]}; tick();
    chk_bit("single b3", 1'b1, 1'b1); rx = {x_o, rx[WIDTH-1:1]}; tick();
    chk("single rx", rx, 4'hB);
    chk_idle("single idle");

    // Back-to-back 4'hA then 4'h5 -> 0,1,0,1,1,0,1,0 with no gap.
    load_valid_i = 1'b1;
    load_data_i  = 4'hA;
    tick();
    chk_bit("b2b a0", 1'b0, 1'b0); tick();
    chk_bit("b2b a1", 1'b1, 1'b0); tick();
    chk_bit("b2b a2", 1'b0, 1'b0); tick();
    chk_bit("b2b a3", 1'b1, 1'b1);
    load_data_i = 4'h5;
    tick();
    load_valid_i = 1'b0;
    chk_bit("b2b 5_0", 1'b1, 1'b0); tick();
    chk_bit("b2b 5_1", 1'b0, 1'b0); tick();
    chk_bit("b2b 5_2", 1'b1, 1'b0); tick();
    chk_bit("b2b 5_3", 1'b0, 1'b1); tick();
    chk_idle("b2b idle");

    // Stall: 4'h3 offered during bit 1 of 4'h9 (1,0,0,1) waits for the last-bit edge.
    load(4'h9);
    chk_bit("stall 9_0", 1'b1, 1'b0); tick();
    load_valid_i = 1'b1;
    load_data_i  = 4'h3;
    chk_bit("stall 9_1", 1'b0, 1'b0); tick();
    chk_bit("stall 9_2", 1'b0, 1'b0); tick();
    chk_bit("stall 9_3", 1'b1, 1'b1); tick();
    load_valid_i = 1'b0;
    chk_bit("stall 3_0", 1'b1, 1'b0); tick();
    chk_bit("stall 3_1", 1'b1, 1'b0); tick();
    chk_bit("stall 3_2", 1'b0, 1'b0); tick();
    chk_bit("stall 3_3", 1'b0, 1'b1); tick();
    chk_idle("stall idle");

    // Reset after two bits of 4'hF aborts immediately; 4'h6 then sends 0,1,1,0.
    load(4'hF);
    chk_bit("abort f0", 1'b1, 1'b0); tick();
    chk_bit("abort f1", 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk_idle("abort async");
    tick();
    reset = 1'b0;
    tick();
    chk_idle("abort released");
    load(4'h6);
    chk_bit("fresh 6_0", 1'b0, 1'b0); tick();
    chk_bit("fresh 6_1", 1'b1, 1'b0); tick();
    chk_bit("fresh 6_2", 1'b1, 1'b0); tick();
    chk_bit("fresh 6_3", 1'b0, 1'b1); tick();
    chk_idle("fresh idle");
`else
    // 4'b0111 -> 1,1,1,0 then parity 1 on the marked last bit.
    load(4'h7);
    chk_bit("par7 b0", 1'b1, 1'b0); tick();
    chk_bit("par7 b1", 1'b1, 1'b0); tick();
    chk_bit("par7 b2", 1'b1, 1'b0); tick();
    chk_bit("par7 b3", 1'b0, 1'b0); tick();
    chk_bit("par7 p",  1'b1, 1'b1); tick();
    chk_idle("par7 idle");

    // 4'b0011 -> 1,1,0,0 then parity 0.
    load(4'h3);
    chk_bit("par3 b0", 1'b1, 1'b0); tick();
    chk_bit("par3 b1", 1'b1, 1'b0); tick();
    chk_bit("par3 b2", 1'b0, 1'b0); tick();
    chk_bit("par3 b3", 1'b0, 1'b0); tick();
    chk_bit("par3 p",  1'b0, 1'b1); tick();
    chk_idle("par3 idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
